// File: rtl/radar_pkg.sv
// radar_pkg
// Shared definitions for the radar CFAR detector slice.
//   DATA_W        : width of the filtered range samples from the FIR stage
//   cfar_state_e  : detector FSM states (FILL while the window is loading, RUN once it is full)
//   cfar_len()    : window length from training/guard cell counts per side
//   cfar_sum_w()  : width of one training-cell running sum (N_TRAIN samples per side)
package radar_pkg;

  localparam int DATA_W = 8;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } cfar_state_e;

  // Window length: both training sides, both guard sides and the cell under test.
  function automatic int cfar_len(input int n_train, input int n_guard);
    return 2 * n_train + 2 * n_guard + 1;
  endfunction

  // Sized for all 2*N_TRAIN training cells, so lead + lag together still fit.
  function automatic int cfar_sum_w(input int data_w, input int n_train);
    return data_w + $clog2(2 * n_train);
  endfunction

endpackage

// File: rtl/cfar_window.sv
// cfar_window
// Sliding CFAR window: L-deep shift register of samples with running lead/lag
// training sums, CUT tap and 1-based sample counter within the sweep. Every
// output is registered on the accept edge and describes the window just after
// the accepted sample was shifted in.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_data/in_last : sample stream (in_last marks the sweep's final sample)
//   win_valid                : one-cycle strobe, a sample was accepted last edge
//   win_last                 : that sample carried in_last
//   win_count                : 1-based sample count k of that sample (wraps)
//   lead_sum/lag_sum         : sums of the lead / lag training cells
//   win_cut                  : sample now sitting in the CUT position
module cfar_window
  import radar_pkg::*;
#(
  parameter int DATA_W  = radar_pkg::DATA_W,
  parameter int N_TRAIN = 8,
  parameter int N_GUARD = 2,
  parameter int BIN_W   = 10,
  localparam int SUM_W  = cfar_sum_w(DATA_W, N_TRAIN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              win_valid,
  output logic              win_last,
  output logic [BIN_W-1:0]  win_count,
  output logic [SUM_W-1:0]  lead_sum,
  output logic [SUM_W-1:0]  lag_sum,
  output logic [DATA_W-1:0] win_cut
);

  localparam int L       = cfar_len(N_TRAIN, N_GUARD);
  localparam int CUT_POS = N_TRAIN + N_GUARD;

  logic [DATA_W-1:0] win [L];
  logic [SUM_W-1:0]  lead_acc;
  logic [SUM_W-1:0]  lag_acc;
  logic [SUM_W-1:0]  lead_next;
  logic [SUM_W-1:0]  lag_next;
  logic [BIN_W-1:0]  cnt;
  logic [BIN_W-1:0]  cnt_next;

  // Incremental sum update for one shift. Lead gains the new sample and loses
  // the cell that moves into the guard band; lag gains the cell leaving the
  // guard band and loses the oldest cell falling off the end. Intermediate
  // wrap-around cancels because the true result is always non-negative.
  always_comb begin
    lead_next = lead_acc + SUM_W'(in_data) - SUM_W'(win[N_TRAIN-1]);
    lag_next  = lag_acc + SUM_W'(win[L-N_TRAIN-1]) - SUM_W'(win[L-1]);
    cnt_next  = cnt + BIN_W'(1);
  end

  // Window state. A sample with in_last is still reported through the output
  // registers below, but the internal window restarts empty so the next sweep
  // enters a cleared window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L; i++) win[i] <= '0;
      lead_acc <= '0;
      lag_acc  <= '0;
      cnt      <= '0;
    end else if (in_valid) begin
      if (in_last) begin
        for (int i = 0; i < L; i++) win[i] <= '0;
        lead_acc <= '0;
        lag_acc  <= '0;
        cnt      <= '0;
      end else begin
        win[0] <= in_data;
        for (int i = 1; i < L; i++) win[i] <= win[i-1];
        lead_acc <= lead_next;
        lag_acc  <= lag_next;
        cnt      <= cnt_next;
      end
    end
  end

  // Registered view of the post-shift window for the threshold stage. The CUT
  // after the shift is the cell one position younger than the current CUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_count <= '0;
      lead_sum  <= '0;
      lag_sum   <= '0;
      win_cut   <= '0;
    end else begin
      win_valid <= in_valid;
      win_last  <= in_valid && in_last;
      if (in_valid) begin
        win_count <= cnt_next;
        lead_sum  <= lead_next;
        lag_sum   <= lag_next;
        win_cut   <= win[CUT_POS-1];
      end
    end
  end

endmodule

// File: rtl/radar_ca_cfar.sv
// radar_ca_cfar
// Cell-averaging CFAR detector fed by the radar FIR stage. Stage 1 (cfar_window)
// shifts the window and updates the training sums; stage 2 here scales the
// average into a threshold, compares the CUT and registers the result.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_data/in_last : filtered sample stream, in_last ends a sweep
//   det_valid                : one-cycle result strobe, 2 cycles after the sample
//   det_hit                  : CUT strictly above threshold
//   det_cut                  : CUT sample value
//   det_thresh               : adaptive threshold
//   det_index                : 0-based range bin of the CUT within the sweep
//   sweep_done               : one-cycle pulse in the result slot of the in_last sample
module radar_ca_cfar
  import radar_pkg::*;
#(
  parameter int DATA_W  = radar_pkg::DATA_W,
  parameter int N_TRAIN = 8,
  parameter int N_GUARD = 2,
  parameter int SCALE   = 3,
  parameter int BIN_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              det_valid,
  output logic              det_hit,
  output logic [DATA_W-1:0] det_cut,
  output logic [DATA_W+3:0] det_thresh,
  output logic [BIN_W-1:0]  det_index,
  output logic              sweep_done
);

  localparam int L       = cfar_len(N_TRAIN, N_GUARD);
  localparam int CUT_POS = N_TRAIN + N_GUARD;
  localparam int SHIFT   = $clog2(2 * N_TRAIN);
  localparam int SUM_W   = cfar_sum_w(DATA_W, N_TRAIN);
  localparam int THR_W   = DATA_W + 4;
  localparam int PROD_W  = DATA_W + 4 + SHIFT;

  logic              win_valid;
  logic              win_last;
  logic [BIN_W-1:0]  win_count;
  logic [SUM_W-1:0]  lead_sum;
  logic [SUM_W-1:0]  lag_sum;
  logic [DATA_W-1:0] win_cut;

  cfar_state_e       state;
  cfar_state_e       state_next;
  logic              produce;
  logic [SUM_W-1:0]  total;
  logic [PROD_W-1:0] product;
  logic [THR_W-1:0]  thresh;
  logic              hit;

  cfar_window #(
    .DATA_W  (DATA_W),
    .N_TRAIN (N_TRAIN),
    .N_GUARD (N_GUARD),
    .BIN_W   (BIN_W)
  ) u_window (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .win_valid (win_valid),
    .win_last  (win_last),
    .win_count (win_count),
    .lead_sum  (lead_sum),
    .lag_sum   (lag_sum),
    .win_cut   (win_cut)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  // Next state and result qualification. The sample that completes the window
  // (k == L) already yields a result while still in FILL; in_last always sends
  // the FSM back to FILL, after its own sample has been evaluated.
  always_comb begin
    state_next = state;
    produce    = 1'b0;
    if (win_valid) begin
      produce = (state == RUN) || (win_count == BIN_W'(L));
      if (win_last)     state_next = FILL;
      else if (produce) state_next = RUN;
    end
  end

  // Threshold: SCALE times the mean of all training cells. Dividing by the
  // power-of-two cell count is a plain right shift.
  always_comb begin
    total   = lead_sum + lag_sum;
    product = PROD_W'(SCALE) * PROD_W'(total);
    thresh  = THR_W'(product >> SHIFT);
    hit     = THR_W'(win_cut) > thresh;
  end

  // Output registers. Data fields only load with a result and otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_valid  <= 1'b0;
      sweep_done <= 1'b0;
      det_hit    <= 1'b0;
      det_cut    <= '0;
      det_thresh <= '0;
      det_index  <= '0;
    end else begin
      det_valid  <= produce;
      sweep_done <= win_valid && win_last;
      if (produce) begin
        det_hit    <= hit;
        det_cut    <= win_cut;
        det_thresh <= thresh;
        det_index  <= win_count - BIN_W'(CUT_POS + 1);
      end
    end
  end

endmodule

// File: doc/radar_ca_cfar.md
# radar_ca_cfar

Cell-averaging CFAR detector that sits directly downstream of the radar FIR stage. It consumes the filtered 8-bit range-sample stream and keeps a sliding window of guard and training cells around a cell under test (CUT). For each bin it emits a registered detection decision with the adaptive threshold and the range-bin index. One sweep is delimited by `in_last`.

## Interface
- `DATA_W`, 8: sample width.
- `N_TRAIN`, 8: training cells per side. Must be a power of 2.
- `N_GUARD`, 2: guard cells per side.
- `SCALE`, 3: threshold multiplier, range 1..15.
- `BIN_W`, 10: range-bin index width.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  sample strobe. No backpressure; gaps allowed.
- `in_data`  in  DATA_W  filtered sample, unsigned.
- `in_last`  in  1  qualifies the final sample of a sweep; meaningful only with `in_valid`.
- `det_valid`  out  1  one-cycle result strobe.
- `det_hit`  out  1  CUT exceeds threshold.
- `det_cut`  out  DATA_W  CUT sample value.
- `det_thresh`  out  DATA_W+4  computed threshold.
- `det_index`  out  BIN_W  range bin of the CUT, 0-based within the sweep.
- `sweep_done`  out  1  one-cycle pulse marking the end of a sweep.

## Operation
- Window length L = 2·N_TRAIN + 2·N_GUARD + 1 (21 by default).
- Window position 0 holds the newest sample. CUT is at position N_TRAIN+N_GUARD.
- Lead training cells: positions 0..N_TRAIN-1. Lag training cells: positions L-N_TRAIN..L-1. Guard cells and the CUT are excluded from the sums.
- Each accepted sample shifts the window by one position. `lead_sum` and `lag_sum` are updated incrementally: add the entering cell, subtract the leaving cell. After every update, both equal the exact sums of their cells.
- Sum width is DATA_W+log2(2·N_TRAIN), 12 bits by default. This width cannot overflow.
- Threshold = (SCALE·(lead_sum+lag_sum)) >> log2(2·N_TRAIN). The product is DATA_W+4+log2(2·N_TRAIN) bits, truncated after the shift to DATA_W+4 bits.
- `det_hit` = CUT > threshold, strictly greater. Equality is not a hit.
- FSM has two states:
  - FILL: sample count k < L. No results are produced. FILL → RUN when the L-th sample of the sweep is accepted; that sample produces the first result.
  - RUN: every accepted sample produces one result.
- Result index = k − 1 − (N_TRAIN+N_GUARD), where k is the 1-based count of the sample just accepted. The sweep counter wraps modulo 2^BIN_W.
- Edge bins (the first and last N_TRAIN+N_GUARD of a sweep) are never reported.
- Accepting a sample with `in_last`:
  - it is evaluated normally if the window is full;
  - `sweep_done` pulses aligned with that sample's result slot, whether or not a result is produced;
  - then window contents, sums and counter clear, and the FSM enters FILL.
- A sweep shorter than L produces no `det_valid`, only `sweep_done`.
- Reset clears the window, sums, counter and all output registers to 0, and sets FSM = FILL. A partial sweep in progress at reset is discarded.

## Timing
- Two-stage pipeline at throughput 1 sample/cycle:
  - Stage 1: window shift and sum update, registered on the accept edge.
  - Stage 2: multiply, shift and compare, registered.
- `det_valid` and `sweep_done` assert exactly 2 cycles after the `in_valid` cycle that caused them, and last 1 cycle.
- `det_hit`, `det_cut`, `det_thresh` and `det_index` are valid only while `det_valid` is high. They hold their last values otherwise; they are not required to clear.
- Back-to-back `in_valid` with `in_last` on consecutive sweeps: the first sample of the new sweep enters a cleared window.
- Asynchronous reset takes effect immediately. Pulses in flight are dropped, and the outputs read 0 while `rst` is high.

## Structure
- `radar_pkg` holds:
  - the shared `DATA_W` constant;
  - the CFAR state enum (FILL, RUN);
  - a constant function for L;
  - a clog2-based function for the sum width.
- One sub-module, `cfar_window`, contains the L-deep shift register, running lead/lag sums, CUT tap and sweep counter. Its outputs are registered.
- The top level holds the FSM, threshold arithmetic, compare and output registers.

## Test plan
All scenarios use default parameters unless stated.

1. **Constant level:** 30 samples of 10, `in_last` on the 30th → 10 results, indices 10..19, `det_thresh`=30, `det_hit`=0 throughout; one `sweep_done`, aligned with index 19.
2. **Single spike:** 30 samples of 0 with 100 at bin 15 → `det_hit`=1 only at index 15 (thresh 0). Results with the spike in training cells show thresh 18 and `det_hit`=0.
3. **Threshold equality:** background of 10 with CUT bin 15 = 30 → bin 15 not a hit. Repeat with CUT = 31 → bin 15 is a hit.
4. **Short sweep:** 20 samples with `in_last` on the 20th → no `det_valid`, one `sweep_done` 2 cycles after the last sample. The next sweep's first result has index 10.
5. **Gapped input and saturation:** `in_valid` every 3rd cycle, 25 samples of 255, SCALE=15 → thresh 3825, no hits, indices 10..14, each `det_valid` 2 cycles after its input.
6. **Reset mid-sweep:** assert `rst` after 25 samples → all outputs 0 immediately. After release, the first `det_valid` appears only after 21 new samples, at index 10.
